// File: rtl/uart_pkg.sv
// Shared UART register map, init constants and the init write table.
package uart_pkg;

  localparam logic [31:0] RBR_THR_DLL = 32'h0000_0000;
  localparam logic [31:0] IER_DLM     = 32'h0000_0004;
  localparam logic [31:0] FCR         = 32'h0000_0008;
  localparam logic [31:0] LCR         = 32'h0000_000C;

  localparam logic [7:0] LCR_DLAB_8N1     = 8'h83;
  localparam logic [7:0] LCR_8N1          = 8'h03;
  localparam logic [7:0] FCR_ENABLE_CLEAR = 8'h07;
  localparam logic [7:0] IER_NONE         = 8'h00;

  localparam int unsigned NUM_INIT_WRITES = 6;

  typedef enum logic [1:0] {
    INIT_SETUP,
    INIT_ACCESS,
    PASS,
    WAIT_IDLE
  } initState_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } apbWrite_t;

  // Address/data of the init write at the given step; the divisor is split over DLL/DLM.
  function automatic apbWrite_t initEntry(input logic [2:0] step, input logic [15:0] div);
    apbWrite_t entry;
    entry.addr = '0;
    entry.data = '0;
    case (step)
      3'd0: begin entry.addr = LCR;         entry.data = {24'h0, LCR_DLAB_8N1}; end
      3'd1: begin entry.addr = RBR_THR_DLL; entry.data = {24'h0, div[7:0]}; end
      3'd2: begin entry.addr = IER_DLM;     entry.data = {24'h0, div[15:8]}; end
      3'd3: begin entry.addr = LCR;         entry.data = {24'h0, LCR_8N1}; end
      3'd4: begin entry.addr = FCR;         entry.data = {24'h0, FCR_ENABLE_CLEAR}; end
      3'd5: begin entry.addr = IER_DLM;     entry.data = {24'h0, IER_NONE}; end
      default: begin entry.addr = '0;       entry.data = '0; end
    endcase
    return entry;
  endfunction

endpackage

// File: rtl/uart_apb_init_ctrl_if.sv
// APB bus bundle used to wire the init controller to the SoC side and the UART side.
interface uart_apb_init_ctrl_if;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/uart_apb_init_ctrl.sv
// Sits between the SoC APB port and apb_uart: programs baud divisor, line format,
// FIFOs and interrupts after reset (or on request), then becomes a transparent bridge.
module uart_apb_init_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned ClkFreqHz = 50000000,
  parameter int unsigned BaudRate  = 115200
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // upstream APB slave (from SoC)
  input  logic        s_psel_i,
  input  logic        s_penable_i,
  input  logic        s_pwrite_i,
  input  logic [31:0] s_paddr_i,
  input  logic [31:0] s_pwdata_i,
  output logic [31:0] s_prdata_o,
  output logic        s_pready_o,
  output logic        s_pslverr_o,
  // downstream APB master (to apb_uart)
  output logic        m_psel_o,
  output logic        m_penable_o,
  output logic        m_pwrite_o,
  output logic [31:0] m_paddr_o,
  output logic [31:0] m_pwdata_o,
  input  logic [31:0] m_prdata_i,
  input  logic        m_pready_i,
  input  logic        m_pslverr_i,
  // control / status
  input  logic        reinit_i,
  output logic        init_done_o,
  output logic        init_err_o
);

  // Divisor rounded to nearest for 16x oversampling.
  localparam int unsigned DivFull  = (ClkFreqHz + 8 * BaudRate) / (16 * BaudRate);
  localparam logic [15:0] Div      = DivFull[15:0];
  localparam logic [2:0]  LastStep = 3'(NUM_INIT_WRITES - 1);

  if (DivFull < 1 || DivFull > 65535) begin : gen_div_check
    $error("uart_apb_init_ctrl: baud divisor %0d out of range 1..65535", DivFull);
  end

  initState_e state_q, state_d;
  logic [2:0] step_q, step_d;
  logic       pending_q, pending_d;
  logic       initErr_q, initErr_d;
  logic       setupNow, accessNow, passNow;
  apbWrite_t  entry;

  // State, step counter, pending-reinit flag and sticky error register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= INIT_SETUP;
      step_q    <= '0;
      pending_q <= 1'b0;
      initErr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      pending_q <= pending_d;
      initErr_q <= initErr_d;
    end
  end

  // Next state plus bus drive; WAIT_IDLE issues the first setup in the very cycle the SoC goes idle.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    pending_d   = pending_q;
    initErr_d   = initErr_q;
    setupNow    = 1'b0;
    accessNow   = 1'b0;
    passNow     = 1'b0;
    entry       = initEntry(step_q, Div);
    m_psel_o    = 1'b0;
    m_penable_o = 1'b0;
    m_pwrite_o  = 1'b0;
    m_paddr_o   = '0;
    m_pwdata_o  = '0;
    s_prdata_o  = '0;
    s_pready_o  = 1'b0;
    s_pslverr_o = 1'b0;

    case (state_q)
      INIT_SETUP: begin
        setupNow = 1'b1;
        state_d  = INIT_ACCESS;
      end
      INIT_ACCESS: begin
        accessNow = 1'b1;
        if (m_pready_i) begin
          initErr_d = initErr_q | m_pslverr_i;
          if (step_q == LastStep) begin
            state_d = PASS;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = INIT_SETUP;
          end
        end
      end
      PASS: begin
        passNow = 1'b1;
        if (reinit_i) begin
          step_d = '0;
          if (s_psel_i) begin
            pending_d = 1'b1;
            state_d   = WAIT_IDLE;
          end else begin
            state_d = INIT_SETUP;
          end
        end
      end
      WAIT_IDLE: begin
        if (s_psel_i || !pending_q) begin
          passNow = 1'b1;
        end else begin
          setupNow  = 1'b1;
          pending_d = 1'b0;
          state_d   = INIT_ACCESS;
        end
      end
      default: state_d = INIT_SETUP;
    endcase

    if (!rst_i) begin
      if (passNow) begin
        m_psel_o    = s_psel_i;
        m_penable_o = s_penable_i;
        m_pwrite_o  = s_pwrite_i;
        m_paddr_o   = s_paddr_i;
        m_pwdata_o  = s_pwdata_i;
        s_prdata_o  = m_prdata_i;
        s_pready_o  = m_pready_i;
        s_pslverr_o = m_pslverr_i;
      end else if (setupNow || accessNow) begin
        m_psel_o    = 1'b1;
        m_penable_o = accessNow;
        m_pwrite_o  = 1'b1;
        m_paddr_o   = entry.addr;
        m_pwdata_o  = entry.data;
      end
    end
  end

  assign init_done_o = passNow & ~rst_i;
  assign init_err_o  = initErr_q;

endmodule
